// File: rtl/ika2151_pkg.sv
// Shared slot constants, request record, FSM state and register-to-slot mapping for the write path.
package ika2151_pkg;
    localparam int         SLOT_W         = 5;
    localparam logic [7:0] REG_GLOBAL_MAX = 8'h20;
    localparam logic [7:0] REG_CH_MAX     = 8'h40;

    typedef enum logic [1:0] {IDLE, WAIT_SLOT, COMMIT} wr_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_req_t;

    function automatic logic is_global(input logic [7:0] addr);
        return addr < REG_GLOBAL_MAX;
    endfunction

    // Channel registers 0x20-0x3F own slots 0-7; operator registers own slot addr[4:0].
    function automatic logic [SLOT_W-1:0] target_slot(input logic [7:0] addr);
        logic [1:0] hi;
        hi = (addr >= REG_CH_MAX) ? addr[4:3] : 2'b00;
        return {hi, addr[2:0]};
    endfunction
endpackage

// File: rtl/ika2151_wrfifo.sv
// Synchronous {addr,data} FIFO with a combinational head; zero-cycle read, one-cycle write.
// No overflow/underflow guard: the owner pushes only when not full (or popping) and pops only when not empty.
module ika2151_wrfifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
endmodule

// File: rtl/ika2151_write_scheduler.sv
// Schedules CPU register writes onto their owning phi1 slot (globals next phi1); commit within 32 phi1 cycles.
// Data writes while busy are dropped with o_DROP; IKA2151_WRFIFO_EN queues them instead, dropping only when full.
module ika2151_write_scheduler
    import ika2151_pkg::*;
#(
    parameter int BUSY_CYCLES = 64
`ifdef IKA2151_WRFIFO_EN
    ,
    parameter int FIFO_DEPTH  = 4
`endif
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_CYCLE_31,
    input  logic       i_CS_n,
    input  logic       i_WR_n,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    output logic       o_BUSY,
    output logic       o_REG_WR,
    output logic [7:0] o_REG_ADDR,
    output logic [7:0] o_REG_DATA,
    output logic       o_DROP
);
    localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);

    logic              rst;
    logic [1:0]        rst_sync;
    logic              ce;
    logic              strobe;
    logic              strobe_q;
    logic              capture;
    logic              addr_wr;
    logic              data_wr;
    logic              accept;
    logic              take;
    logic              pend;
    logic              busy;
    logic              hit;
    logic              drop;
    logic [7:0]        addr_latch;
    logic [SLOT_W-1:0] slot_cnt;
    logic [SLOT_W-1:0] slot_nxt;
    logic [BUSY_W-1:0] busy_cnt;
    wr_state_t         state;
    wr_state_t         state_nxt;
    wr_req_t           new_req;
    wr_req_t           cur_req;
    wr_req_t           sel_req;

    // Reset asserts at once and releases two EMUCLK edges later.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) rst_sync <= 2'b11;
        else       rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst = rst_sync[1];

    assign ce       = ~i_phi1_NCEN_n;
    assign strobe   = i_CS_n | i_WR_n;
    assign capture  = strobe & ~strobe_q;
    assign addr_wr  = capture & ~i_A0;
    assign data_wr  = capture & i_A0;
    assign new_req  = {addr_latch, i_D};
    assign slot_nxt = i_CYCLE_31 ? '0 : slot_cnt + 1'b1;
    assign take     = ce & (state == IDLE) & pend;
    // Match against the slot that starts on this enable, so COMMIT spans the owning slot.
    assign hit      = is_global(sel_req.addr) || (slot_nxt == target_slot(sel_req.addr));

    always_ff @(posedge i_EMUCLK or posedge rst) begin
        if (rst) begin
            strobe_q   <= 1'b1;
            addr_latch <= '0;
            slot_cnt   <= '0;
            busy_cnt   <= '0;
            state      <= IDLE;
            drop       <= 1'b0;
        end else begin
            strobe_q <= strobe;
            drop     <= data_wr & ~accept;
            state    <= state_nxt;
            if (addr_wr) addr_latch <= i_D;
            if (ce)      slot_cnt   <= slot_nxt;
            if (accept)
                busy_cnt <= BUSY_W'(BUSY_CYCLES);
            else if (ce && busy_cnt != '0)
                busy_cnt <= busy_cnt - 1'b1;
        end
    end

`ifdef IKA2151_WRFIFO_EN
    logic    fifo_empty;
    logic    fifo_full;
    wr_req_t fifo_head;

    assign pend    = ~fifo_empty;
    assign accept  = data_wr & (~fifo_full | take);
    assign busy    = fifo_full | (busy_cnt != '0);
    assign sel_req = (state == IDLE) ? fifo_head : cur_req;

    ika2151_wrfifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(wr_req_t))
    ) u_wrfifo (
        .clk      (i_EMUCLK),
        .rst      (rst),
        .push     (accept),
        .push_dat (new_req),
        .pop      (take),
        .pop_dat  (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge i_EMUCLK or posedge rst) begin
        if (rst)       cur_req <= '0;
        else if (take) cur_req <= fifo_head;
    end
`else
    logic req_vld;

    assign pend    = req_vld;
    assign accept  = data_wr & ~busy;
    assign busy    = (busy_cnt != '0) | (state != IDLE) | req_vld;
    assign sel_req = cur_req;

    // cur_req keeps its own address copy, so later address-port writes cannot disturb it.
    always_ff @(posedge i_EMUCLK or posedge rst) begin
        if (rst) begin
            req_vld <= 1'b0;
            cur_req <= '0;
        end else if (accept) begin
            req_vld <= 1'b1;
            cur_req <= new_req;
        end else if (take) begin
            req_vld <= 1'b0;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (ce && pend) state_nxt = hit ? COMMIT : WAIT_SLOT;
            WAIT_SLOT: if (ce && hit)  state_nxt = COMMIT;
            COMMIT:    if (ce)         state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign o_BUSY     = busy;
    assign o_REG_WR   = (state == COMMIT);
    assign o_REG_ADDR = cur_req.addr;
    assign o_REG_DATA = cur_req.data;
    assign o_DROP     = drop;
endmodule

// File: tb/tb_ika2151_write_scheduler.sv
// Bench for the write scheduler: table of register writes plus hand-written busy, drop, rewrite and reset sequences.
module tb_ika2151_write_scheduler;
    localparam int PHI_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ncen = 1'b1;
    logic       cyc31 = 1'b0;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] d = 8'h00;
    logic       busy;
    logic       reg_wr;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       drop;

    ika2151_write_scheduler dut (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phi1_NCEN_n (ncen),
        .i_CYCLE_31    (cyc31),
        .i_CS_n        (cs_n),
        .i_WR_n        (wr_n),
        .i_A0          (a0),
        .i_D           (d),
        .o_BUSY        (busy),
        .o_REG_WR      (reg_wr),
        .o_REG_ADDR    (reg_addr),
        .o_REG_DATA    (reg_data),
        .o_DROP        (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         slot;   // -1: global, no slot alignment
    } exp_t;

    exp_t sb[$];
    exp_t vt[10];

    int  n_chk = 0;
    int  n_pass = 0;
    int  tg_slot = 20;      // timing generator starts out of phase with the DUT counter
    int  ce_count = 0;
    int  div = 0;
    bit  phi_run = 1'b0;
    bit  cyc31_en = 1'b1;
    int  commits = 0;
    int  drops = 0;
    int  last_commit_ce = 0;
    int  cap = 0;
    int  wr_len = 0;
    bit  skip_width = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] v, input int s);
        exp_t e;
        e.addr = a;
        e.data = v;
        e.slot = s;
        return e;
    endfunction

    // Timing generator: phi1 enable every PHI_DIV clocks, CYCLE_31 during slot 31.
    initial begin
        forever begin
            @(posedge clk);
            if (ncen == 1'b0) begin
                tg_slot = cyc31 ? 0 : (tg_slot + 1) % 32;
                ce_count++;
            end
            #1;
            div   = (div + 1) % PHI_DIV;
            ncen  = !(phi_run && div == 0);
            cyc31 = cyc31_en && (tg_slot == 31);
        end
    end

    // Commit/drop monitor against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (drop === 1'b1) drops++;
            if (reg_wr === 1'b1) begin
                if (wr_len == 0) begin
                    commits++;
                    last_commit_ce = ce_count;
                    if (sb.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_commit: got addr %0h data %0h, want none", reg_addr, reg_data);
                    end else begin
                        e = sb.pop_front();
                        check("commit_addr", int'(reg_addr), int'(e.addr));
                        check("commit_data", int'(reg_data), int'(e.data));
                        if (e.slot >= 0) check("commit_slot", tg_slot, e.slot);
                    end
                end
                wr_len++;
            end else if (wr_len != 0) begin
                if (!skip_width) check("commit_width", wr_len, PHI_DIV);
                skip_width = 1'b0;
                wr_len = 0;
            end
        end
    end

    task automatic bus_write(input bit is_data, input logic [7:0] v);
        @(posedge clk); #2;
        cs_n = 1'b0; wr_n = 1'b0; a0 = is_data; d = v;
        @(posedge clk); #2;
        cs_n = 1'b1; wr_n = 1'b1;
        @(posedge clk); #2;
        cap = ce_count;
    endtask

    task automatic wait_ces(input int n);
        int t0;
        int k;
        t0 = ce_count;
        k = 0;
        while (ce_count - t0 < n && k < n * PHI_DIV * 4) begin
            @(negedge clk);
            k++;
        end
        if (ce_count - t0 < n) begin
            n_chk++;
            $display("FAIL wait_ces_timeout: got %0d enables, want %0d", ce_count - t0, n);
        end
    endtask

    task automatic wait_slot(input int s);
        int c;
        int n;
        c = ce_count;
        n = 0;
        while (!(ce_count != c && tg_slot == s) && n < 1000) begin
            c = ce_count;
            @(posedge clk); #2;
            n++;
        end
        if (n >= 1000) begin
            n_chk++;
            $display("FAIL wait_slot_timeout: got slot %0d, want %0d", tg_slot, s);
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) begin
            n_chk++;
            $display("FAIL idle_timeout: got busy %0b pending %0d, want idle", busy, sb.size());
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int d0;
        int n;
        vt[0] = mk(8'h08, 8'h7A, -1);
        vt[1] = mk(8'h5B, 8'hC3, 27);
        vt[2] = mk(8'h28, 8'h55, 0);
        vt[3] = mk(8'h3F, 8'h01, 7);
        vt[4] = mk(8'h40, 8'hAA, 0);
        vt[5] = mk(8'hFF, 8'h5A, 31);
        vt[6] = mk(8'h1F, 8'hE0, -1);
        vt[7] = mk(8'h20, 8'h99, 0);
        vt[8] = mk(8'h9D, 8'h12, 29);
        vt[9] = mk(8'h6A, 8'h34, 10);

        #1 rst = 1'b1;
        #20;
        check("rst_busy", int'(busy), 0);
        check("rst_reg_wr", int'(reg_wr), 0);
        check("rst_reg_addr", int'(reg_addr), 0);
        check("rst_reg_data", int'(reg_data), 0);
        check("rst_drop", int'(drop), 0);
        @(negedge clk) rst = 1'b0;
        phi_run = 1'b1;
        wait_ces(40);

        for (int i = 0; i < 10; i++) begin
            bus_write(1'b0, vt[i].addr);
            sb.push_back(vt[i]);
            bus_write(1'b1, vt[i].data);
            check($sformatf("v%0d_busy_set", i), int'(busy), 1);
            wait_idle(2000);
            check($sformatf("v%0d_busy_len", i), ce_count - cap, 64);
            if (vt[i].slot < 0) check($sformatf("v%0d_global_latency", i), last_commit_ce - cap, 1);
        end

        // Operator register written while the slot counter reads 4.
        bus_write(1'b0, 8'h5B);
        wait_slot(4);
        sb.push_back(mk(8'h5B, 8'h3C, 27));
        bus_write(1'b1, 8'h3C);
        wait_idle(2000);
        check("op_latency", last_commit_ce - cap, 23);

        // Address port rewritten while the request waits for slot 0.
        bus_write(1'b0, 8'h28);
        wait_slot(5);
        sb.push_back(mk(8'h28, 8'h66, 0));
        bus_write(1'b1, 8'h66);
        wait_ces(4);
        check("rewrite_still_waiting", int'(reg_wr), 0);
        bus_write(1'b0, 8'h30);
        wait_idle(2000);
        sb.push_back(mk(8'h30, 8'h77, 0));
        bus_write(1'b1, 8'h77);
        wait_idle(2000);

        // Free-running slot counter with CYCLE_31 absent.
        cyc31_en = 1'b0;
        bus_write(1'b0, 8'h9D);
        sb.push_back(mk(8'h9D, 8'h21, 29));
        bus_write(1'b1, 8'h21);
        wait_idle(2000);
        bus_write(1'b0, 8'hFF);
        sb.push_back(mk(8'hFF, 8'h22, 31));
        bus_write(1'b1, 8'h22);
        wait_idle(2000);
        cyc31_en = 1'b1;

`ifdef IKA2151_WRFIFO_EN
        phi_run = 1'b0;
        repeat (8) @(posedge clk);
        c0 = commits;
        for (int k = 0; k < 4; k++) begin
            bus_write(1'b0, 8'(8'h60 + k));
            sb.push_back(mk(8'(8'h60 + k), 8'(8'hA0 + k), k));
            bus_write(1'b1, 8'(8'hA0 + k));
        end
        check("fifo_busy", int'(busy), 1);
        d0 = drops;
        bus_write(1'b0, 8'h64);
        bus_write(1'b1, 8'hEE);
        @(negedge clk); #1;
        check("fifo_full_drop", drops - d0, 1);
        phi_run = 1'b1;
        wait_idle(4000);
        check("fifo_commits", commits - c0, 4);
`else
        c0 = commits;
        bus_write(1'b0, 8'h10);
        sb.push_back(mk(8'h10, 8'hAB, -1));
        bus_write(1'b1, 8'hAB);
        repeat (5) @(posedge clk);
        d0 = drops;
        bus_write(1'b1, 8'h11);
        @(negedge clk); #1;
        check("busy_drop", drops - d0, 1);
        wait_idle(2000);
        check("busy_drop_commits", commits - c0, 1);
`endif

        // Reset while waiting for the slot: request lost, no later commit.
        bus_write(1'b0, 8'h5B);
        wait_slot(5);
        bus_write(1'b1, 8'h99);
        wait_ces(3);
        check("wait_busy", int'(busy), 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_wait_busy", int'(busy), 0);
        check("rst_wait_reg_wr", int'(reg_wr), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        c0 = commits;
        wait_ces(45);
        check("rst_wait_no_commit", commits - c0, 0);
        check("rst_wait_idle_busy", int'(busy), 0);

        // Reset in the middle of a commit strobe.
        bus_write(1'b0, 8'h0F);
        sb.push_back(mk(8'h0F, 8'h42, -1));
        bus_write(1'b1, 8'h42);
        n = 0;
        while (reg_wr !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("commit_seen", int'(reg_wr), 1);
        #1;
        skip_width = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_commit_reg_wr", int'(reg_wr), 0);
        check("rst_commit_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        wait_ces(40);
        check("final_sb_empty", sb.size(), 0);
        check("total_drops", drops, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
